mac_window_accum: RTL and testbench
===================================

Name: mac_window_accum

Overview:
- Windowed multiply-accumulate stage built around the team's 12x12 unsigned multiplier IP core, Gowin_MULT_12b.
  - Registered inputs and registered output; 2-cycle latency.
- Accepts a valid/ready stream of 12-bit operand pairs, feeds the multiplier, and sums WIN_LEN products.
- At the end of each window it emits the sum with a one-cycle valid pulse and a sticky overflow flag.
- Sits directly downstream of the multiplier and consumes its 24-bit products; it also owns the multiplier's control pins.

Parameters:
- WIN_LEN, 256, number of operand pairs per window (range 2..65535).
- ACC_W, 32, accumulator and result width (range 24..48).
- MULT_LAT, 2, multiplier latency in cycles; fixed by the IP core and not to be overridden.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset; also drives the multiplier's reset pin.
- abort  in  1  synchronous window abandon, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept a pair.
- in_a  in  12  unsigned operand A.
- in_b  in  12  unsigned operand B.
- acc_valid  out  1  one-cycle pulse; acc_data/acc_ovf carry a new result.
- acc_data  out  ACC_W  window sum, saturated.
- acc_ovf  out  1  window saturated at least once.
- busy  out  1  window in progress (state != IDLE).

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: in_ready=1, acc_valid=0, acc_data=0, acc_ovf=0, busy=0, state=IDLE, sample count=0, accumulator=0, valid pipe=00.
- Multiplier hookup: ce tied 1; reset=reset; a=in_a; b=in_b. The product is qualified by a 2-bit valid shift register loaded with (in_valid & in_ready).
- Accept: a pair is accepted at a rising edge where in_valid & in_ready. Data on non-accepted cycles is ignored.
- Timing for a pair accepted at edge k:
  - product is on the multiplier output after edge k+1;
  - accumulator adds the zero-extended 24-bit product at edge k+2.
- Saturation: if sum > 2^ACC_W-1, the accumulator holds all-ones and the window overflow flag sets. The flag is sticky until the window ends.
- States:
  - IDLE: in_ready=1, count=0. First accept -> ACCUM (count=1).
  - ACCUM: in_ready=1. Each accept increments count. The accept that makes count=WIN_LEN -> DRAIN; the WIN_LEN-th accept is still performed.
  - DRAIN: in_ready=0. Lasts exactly 3 cycles after the last accept at edge k. At edge k+3:
    - acc_data <= final sum; acc_ovf <= window flag; acc_valid <= 1;
    - accumulator and flag cleared; count=0; -> IDLE.
- Result timing: acc_valid is high only in the cycle between edges k+3 and k+4. acc_data/acc_ovf hold until the next result.
- Back-to-back windows: the next window's first pair may be accepted at edge k+4, i.e. in the cycle where acc_valid=1. Window-to-window bubble is 3 cycles.
- in_valid gaps in ACCUM: no effect other than stalling; no timeout.
- abort (any state): at that edge → IDLE, count=0, accumulator=0, flag=0, valid pipe=00, and the abort-edge pair is not accepted. No acc_valid is produced for the abandoned window; acc_data/acc_ovf keep the previous result.
  - If abort coincides with the DRAIN completion edge, abort wins: no acc_valid.
- reset mid-window: same as abort, plus acc_data/acc_ovf cleared to 0.
- in_ready is combinational from state only; no combinational path from in_valid.

Decomposition:
- Shared package (mac_pkg):
  - state enum {IDLE, ACCUM, DRAIN};
  - MULT_W=24 and OPND_W=12 constants;
  - MULT_LAT=2 constant.
- Sub-module: one instance of Gowin_MULT_12b. Everything else (FSM, counter, valid pipe, saturating adder) stays in mac_window_accum.

Test Plan:
- WIN_LEN=4, ACC_W=32, pairs (4095,4095) x4 back-to-back -> acc_valid exactly 3 cycles after the 4th accept, acc_data=67076100, acc_ovf=0. in_ready low for exactly those 3 cycles.
- WIN_LEN=4, pairs (1,2),(3,4),(5,6),(7,8) with in_valid gaps of 0,2,5 cycles -> acc_data=100, single acc_valid pulse.
- WIN_LEN=4, ACC_W=25, pairs (4095,4095) x4 -> acc_data=33554431 (saturated), acc_ovf=1. Next window of (1,1) x4 -> acc_data=4, acc_ovf=0.
- Two windows back-to-back, second's first pair presented during the acc_valid cycle:
  - second window's first pair is accepted at edge k+4, during the acc_valid cycle;
  - results 4 then 8 for windows of (1,1)x4 and (2,1)x4.
- abort asserted after 2 of 4 pairs, then a full window of (2,3)x4 -> no acc_valid for the aborted window; next acc_data=24. Repeat with abort on the DRAIN completion edge -> no pulse, acc_data unchanged.
- reset asserted in ACCUM and again during DRAIN -> all outputs return to reset values the next cycle; in_ready=1; a subsequent (1,1)x4 window gives acc_data=4.

Source files
------------

// File: rtl/mac_window_accum_pkg.sv
// Shared types and constants for the windowed multiply-accumulate stage.
package mac_pkg;

    // Operand and product widths of the 12x12 unsigned multiplier core
    localparam int OPND_W   = 12;
    localparam int MULT_W   = 24;

    // Multiplier latency from accepted operands to valid product
    localparam int MULT_LAT = 2;

    // Window sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/mac_window_accum_mult.sv
// Behavioural model of the Gowin_MULT_12b 12x12 unsigned multiplier core.
// Operands and product are both registered, giving a two-cycle latency.
module Gowin_MULT_12b
    import mac_pkg::*;
(
    output logic [MULT_W-1:0] dout,
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    input  logic              ce,
    input  logic              clk,
    input  logic              reset
);

    logic [OPND_W-1:0] r_a;
    logic [OPND_W-1:0] r_b;
    logic [MULT_W-1:0] r_dout;

    // Input register stage followed by the product register stage
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_dout <= '0;
        end else if (ce) begin
            r_a    <= a;
            r_b    <= b;
            r_dout <= MULT_W'(r_a) * MULT_W'(r_b);
        end
    end

    assign dout = r_dout;

endmodule

// File: rtl/mac_window_accum.sv
// Windowed multiply-accumulate: sums WIN_LEN products from the multiplier
// core with saturation and emits one result pulse per completed window.
module mac_window_accum
    import mac_pkg::*;
#(
    parameter int WIN_LEN = 256,
    parameter int ACC_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPND_W-1:0] in_a,
    input  logic [OPND_W-1:0] in_b,
    output logic              acc_valid,
    output logic [ACC_W-1:0]  acc_data,
    output logic              acc_ovf,
    output logic              busy
);

    localparam int         CNT_W    = 16;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIN_LEN - 1);

    state_t              r_state;
    logic [CNT_W-1:0]    r_count;
    logic [MULT_LAT-1:0] r_vpipe;
    logic [ACC_W-1:0]    r_acc;
    logic                r_winOvf;
    logic [1:0]          r_drainCnt;
    logic                r_accValid;
    logic [ACC_W-1:0]    r_accData;
    logic                r_accOvf;

    logic [MULT_W-1:0]   w_product;
    logic                w_accept;
    logic [ACC_W:0]      w_sum;
    logic                w_sat;

    // The multiplier runs freely; the valid pipe decides which products count
    Gowin_MULT_12b u_mult (
        .dout  (w_product),
        .a     (in_a),
        .b     (in_b),
        .ce    (1'b1),
        .clk   (clk),
        .reset (reset)
    );

    // Ready depends on state alone so upstream never sees a loop through in_valid
    always_comb begin
        in_ready = (r_state != DRAIN);
        busy     = (r_state != IDLE);
        w_accept = in_valid & in_ready & ~abort;
        w_sum    = {1'b0, r_acc} + (ACC_W+1)'(w_product);
        w_sat    = w_sum[ACC_W];
    end

    // Window sequencer, valid pipe, saturating accumulator and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_vpipe    <= '0;
            r_acc      <= '0;
            r_winOvf   <= 1'b0;
            r_drainCnt <= '0;
            r_accValid <= 1'b0;
            r_accData  <= '0;
            r_accOvf   <= 1'b0;
        end else if (abort) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_vpipe    <= '0;
            r_acc      <= '0;
            r_winOvf   <= 1'b0;
            r_drainCnt <= '0;
            r_accValid <= 1'b0;
        end else begin
            r_accValid <= 1'b0;
            r_vpipe    <= {r_vpipe[MULT_LAT-2:0], w_accept};

            if (r_vpipe[MULT_LAT-1]) begin
                r_acc <= w_sat ? '1 : w_sum[ACC_W-1:0];
                if (w_sat) begin
                    r_winOvf <= 1'b1;
                end
            end

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_count <= CNT_W'(1);
                        r_state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (w_accept) begin
                        r_count <= r_count + CNT_W'(1);
                        if (r_count == LAST_IDX) begin
                            r_drainCnt <= '0;
                            r_state    <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Three cycles let the last product land in the accumulator
                    if (r_drainCnt == 2'd2) begin
                        r_accData  <= r_acc;
                        r_accOvf   <= r_winOvf;
                        r_accValid <= 1'b1;
                        r_acc      <= '0;
                        r_winOvf   <= 1'b0;
                        r_count    <= '0;
                        r_drainCnt <= '0;
                        r_state    <= IDLE;
                    end else begin
                        r_drainCnt <= r_drainCnt + 2'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign acc_valid = r_accValid;
    assign acc_data  = r_accData;
    assign acc_ovf   = r_accOvf;

endmodule

// File: tb/tb_mac_window_accum.sv
// Bench for mac_window_accum: two instances (32-bit and 25-bit accumulators)
// share one stimulus stream; a window-level model predicts results.
module tb_mac_window_accum;

    localparam int WIN_LEN = 4;

    typedef struct {
        logic [31:0] data32;
        logic        ovf32;
        logic [24:0] data25;
        logic        ovf25;
    } expect_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        abort = 1'b0;
    logic        inValid = 1'b0;
    logic [11:0] inA = '0;
    logic [11:0] inB = '0;

    logic        ready32, valid32, ovf32, busy32;
    logic [31:0] data32;
    logic        ready25, valid25, ovf25, busy25;
    logic [24:0] data25;

    expect_t     expQ[$];
    expect_t     pendingExp;
    expect_t     popped;
    int          assertCount = 0;
    int          failCount = 0;
    int          edgeNum = 0;
    int          winCount = 0;
    int          drainLeft = 0;
    longint      winSum = 0;
    bit          modelAccepted = 0;
    bit          monitorOn = 0;
    logic        expValid;
    logic [31:0] held32 = '0;
    logic        heldOvf32 = 1'b0;
    logic [24:0] held25 = '0;
    logic        heldOvf25 = 1'b0;

    // Free-running clock
    always #5 clk = ~clk;

    // Two widths so saturation and non-saturation are seen on the same traffic
    mac_window_accum #(.WIN_LEN(WIN_LEN), .ACC_W(32)) u_dut32 (
        .clk(clk), .reset(reset), .abort(abort), .in_valid(inValid),
        .in_ready(ready32), .in_a(inA), .in_b(inB), .acc_valid(valid32),
        .acc_data(data32), .acc_ovf(ovf32), .busy(busy32)
    );

    mac_window_accum #(.WIN_LEN(WIN_LEN), .ACC_W(25)) u_dut25 (
        .clk(clk), .reset(reset), .abort(abort), .in_valid(inValid),
        .in_ready(ready25), .in_a(inA), .in_b(inB), .acc_valid(valid25),
        .acc_data(data25), .acc_ovf(ovf25), .busy(busy25)
    );

    // Single comparison point shared by every check
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at edge %0d: got %0h expected %0h",
                     name, edgeNum, actual, expected);
        end
    endtask

    // Final window sum clipped to each accumulator width
    function automatic expect_t makeExp(input longint s);
        expect_t e;
        longint  m32 = (64'sd1 <<< 32) - 1;
        longint  m25 = (64'sd1 <<< 25) - 1;
        e.ovf32  = (s > m32);
        e.data32 = e.ovf32 ? 32'(m32) : 32'(s);
        e.ovf25  = (s > m25);
        e.data25 = e.ovf25 ? 25'(m25) : 25'(s);
        return e;
    endfunction

    // Window-level model advanced once per rising edge
    task automatic modelEdge();
        edgeNum++;
        modelAccepted = 0;
        if (reset) begin
            winSum = 0; winCount = 0; drainLeft = 0;
            held32 = '0; heldOvf32 = 1'b0; held25 = '0; heldOvf25 = 1'b0;
            expQ.delete();
        end else if (abort) begin
            winSum = 0; winCount = 0; drainLeft = 0;
        end else if (drainLeft > 0) begin
            drainLeft--;
            if (drainLeft == 0) expQ.push_back(pendingExp);
        end else if (inValid) begin
            modelAccepted = 1;
            winSum += longint'(inA) * longint'(inB);
            winCount++;
            if (winCount == WIN_LEN) begin
                pendingExp = makeExp(winSum);
                winSum = 0;
                winCount = 0;
                drainLeft = 3;
            end
        end
    endtask

    // Drive one cycle of inputs and advance the model at the following edge
    task automatic applyStimulus(input logic v, input logic [11:0] a,
                                 input logic [11:0] b, input logic ab,
                                 input logic rs);
        @(negedge clk);
        inValid = v; inA = a; inB = b; abort = ab; reset = rs;
        @(posedge clk);
        modelEdge();
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 12'($urandom), 12'($urandom), 1'b0, 1'b0);
    endtask

    // Present one pair after a gap and hold it until accepted
    task automatic sendPair(input logic [11:0] a, input logic [11:0] b, input int gap);
        int tries = 0;
        idleCycles(gap);
        do begin
            applyStimulus(1'b1, a, b, 1'b0, 1'b0);
            tries++;
        end while (!modelAccepted && tries < 20);
        if (!modelAccepted) checkOutput("acceptTimeout", 64'd0, 64'd1);
    endtask

    task automatic sendWindow(input logic [11:0] a, input logic [11:0] b, input int gap);
        for (int i = 0; i < WIN_LEN; i++) sendPair(a, b, gap);
    endtask

    // Monitor: compares handshake, status and result outputs every cycle
    always @(negedge clk) begin
        if (monitorOn) begin
            checkOutput("inReady32", 64'(ready32), 64'(drainLeft == 0));
            checkOutput("inReady25", 64'(ready25), 64'(drainLeft == 0));
            checkOutput("busy32", 64'(busy32), 64'(winCount > 0 || drainLeft > 0));
            checkOutput("busy25", 64'(busy25), 64'(winCount > 0 || drainLeft > 0));
            expValid = (expQ.size() > 0);
            if (expValid) begin
                popped    = expQ.pop_front();
                held32    = popped.data32;
                heldOvf32 = popped.ovf32;
                held25    = popped.data25;
                heldOvf25 = popped.ovf25;
            end
            checkOutput("accValid32", 64'(valid32), 64'(expValid));
            checkOutput("accValid25", 64'(valid25), 64'(expValid));
            checkOutput("accData32", 64'(data32), 64'(held32));
            checkOutput("accOvf32", 64'(ovf32), 64'(heldOvf32));
            checkOutput("accData25", 64'(data25), 64'(held25));
            checkOutput("accOvf25", 64'(ovf25), 64'(heldOvf25));
        end
    end

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios followed by randomized traffic
    initial begin
        applyStimulus(1'b0, 12'd0, 12'd0, 1'b0, 1'b1);
        monitorOn = 1;
        applyStimulus(1'b0, 12'd0, 12'd0, 1'b0, 1'b1);
        idleCycles(2);

        $display("[TB] full-scale window, back-to-back pairs");
        sendWindow(12'd4095, 12'd4095, 0);
        idleCycles(5);

        $display("[TB] gapped window");
        sendPair(12'd1, 12'd2, 0);
        sendPair(12'd3, 12'd4, 0);
        sendPair(12'd5, 12'd6, 2);
        sendPair(12'd7, 12'd8, 5);
        idleCycles(5);

        $display("[TB] saturating window then small window");
        sendWindow(12'd4095, 12'd4095, 0);
        sendWindow(12'd1, 12'd1, 0);
        idleCycles(5);

        $display("[TB] back-to-back windows");
        sendWindow(12'd1, 12'd1, 0);
        sendWindow(12'd2, 12'd1, 0);
        idleCycles(5);

        $display("[TB] abort mid-window");
        sendPair(12'd100, 12'd100, 0);
        sendPair(12'd200, 12'd50, 0);
        applyStimulus(1'b1, 12'd9, 12'd9, 1'b1, 1'b0);
        sendWindow(12'd2, 12'd3, 0);
        idleCycles(5);

        $display("[TB] abort on drain completion edge");
        sendWindow(12'd7, 12'd7, 0);
        idleCycles(2);
        applyStimulus(1'b0, 12'd0, 12'd0, 1'b1, 1'b0);
        idleCycles(5);

        $display("[TB] reset in accumulate and in drain");
        sendPair(12'd11, 12'd11, 0);
        sendPair(12'd12, 12'd12, 0);
        applyStimulus(1'b1, 12'd1, 12'd1, 1'b0, 1'b1);
        sendWindow(12'd1, 12'd1, 0);
        idleCycles(5);
        sendWindow(12'd3, 12'd3, 0);
        idleCycles(1);
        applyStimulus(1'b0, 12'd0, 12'd0, 1'b0, 1'b1);
        sendWindow(12'd1, 12'd1, 0);
        idleCycles(5);

        $display("[TB] randomized traffic");
        for (int w = 0; w < 40; w++) begin
            for (int p = 0; p < WIN_LEN; p++) begin
                if ($urandom_range(0, 24) == 0)
                    applyStimulus(1'($urandom), 12'($urandom), 12'($urandom), 1'b1, 1'b0);
                if ($urandom_range(0, 3) == 0)
                    sendPair(12'd4095 - 12'($urandom_range(0, 3)), 12'($urandom), $urandom_range(0, 3));
                else
                    sendPair(12'($urandom), 12'($urandom), $urandom_range(0, 3));
            end
        end
        idleCycles(8);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
